// File: rtl/pipe_pkg.sv
// pipe_pkg: control_unit jump/branch encodings and the bubble instruction word shared across the pipeline.
package pipe_pkg;
    localparam logic [1:0] JMP_SEQ = 2'b11;
    localparam logic [1:0] JMP_J   = 2'b01;
    localparam logic [1:0] JMP_JR  = 2'b10;
    localparam logic [1:0] JMP_BR  = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: decides whether the ID-stage instruction redirects fetch, and where to.
module next_pc_calc
    import pipe_pkg::*;
(
    input  logic        valid,
    input  logic [1:0]  jump,
    input  logic [1:0]  branch_inst,
    input  logic        rs_eq_rt,
    input  logic [31:0] rs_data,
    input  logic [25:0] instr_low,
    input  logic [31:0] pc_plus4,
    output logic        redirect,
    output logic [31:0] target
);
    logic taken_br;
    always_comb begin
        taken_br = (jump == JMP_BR) && ((branch_inst == BR_BEQ && rs_eq_rt) || (branch_inst == BR_BNE && !rs_eq_rt));
        redirect = valid && (jump == JMP_J || jump == JMP_JR || taken_br);
        target   = jump == JMP_J  ? {pc_plus4[31:28], instr_low, 2'b00} :
                   jump == JMP_JR ? rs_data :
                   pc_plus4 + {{14{instr_low[15]}}, instr_low[15:0], 2'b00};
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, IF/ID register and the pending-redirect holder that keeps a redirect alive
// while the delay slot is still waiting on instruction memory.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        id_valid,
    input  logic [1:0]  id_jump,
    input  logic [1:0]  id_branch_inst,
    input  logic        id_rs_eq_rt,
    input  logic [31:0] id_rs_data,
    input  logic [25:0] id_instr_low,
    input  logic [31:0] id_pc_plus4,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);
    logic        redirect, pend_valid;
    logic [31:0] target, pend_target, pc_plus4;
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    next_pc_calc u_next_pc (
        .valid      (id_valid),
        .jump       (id_jump),
        .branch_inst(id_branch_inst),
        .rs_eq_rt   (id_rs_eq_rt),
        .rs_data    (id_rs_data),
        .instr_low  (id_instr_low),
        .pc_plus4   (id_pc_plus4),
        .redirect   (redirect),
        .target     (target)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            pend_valid     <= 1'b0;
            pend_target    <= 32'd0;
        end else if (!stall) begin
            if (!imem_ready) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
                // an already-pending target outranks any (illegal) second redirect
                if (redirect && !pend_valid) begin
                    pend_valid  <= 1'b1;
                    pend_target <= target;
                end
            end else begin
                if_id_instr    <= imem_rdata;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b1;
                pc             <= pend_valid ? pend_target : redirect ? target : pc_plus4;
                pend_valid     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan cases plus randomized traffic, checked every cycle against a behavioural model.
module tb_fetch_stage;
    logic        clk = 0;
    logic        rst;
    logic [31:0] imem_addr, imem_rdata, id_rs_data, id_pc_plus4;
    logic [31:0] pc, if_id_instr, if_id_pc_plus4;
    logic        imem_ready, stall, id_valid, id_rs_eq_rt, if_id_valid;
    logic [1:0]  id_jump, id_branch_inst;
    logic [25:0] id_instr_low;
    int vectors = 0, miscompares = 0;
    bit started = 0;
    logic [31:0] m_pc, m_instr, m_pp4, m_pt;
    logic        m_valid, m_pend;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction
    assign imem_rdata = mem_word(imem_addr);

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .stall(stall), .id_valid(id_valid), .id_jump(id_jump), .id_branch_inst(id_branch_inst),
        .id_rs_eq_rt(id_rs_eq_rt), .id_rs_data(id_rs_data), .id_instr_low(id_instr_low),
        .id_pc_plus4(id_pc_plus4), .pc(pc), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
    );

    // returns {taken, target} from the architectural jump/branch rules
    function automatic logic [32:0] model_redirect();
        int off;
        if (!id_valid) return 33'd0;
        case (id_jump)
            2'b01: return {1'b1, (id_pc_plus4 & 32'hF000_0000) | ({6'd0, id_instr_low} << 2)};
            2'b10: return {1'b1, id_rs_data};
            2'b00: begin
                off = int'($signed(id_instr_low[15:0])) * 4;
                if ((id_branch_inst == 2'd1 && id_rs_eq_rt) || (id_branch_inst == 2'd2 && !id_rs_eq_rt))
                    return {1'b1, id_pc_plus4 + 32'(off)};
                return 33'd0;
            end
            default: return 33'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [32:0] r;
        if (rst) begin
            m_pc = 32'd0; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 0; m_pend = 0; m_pt = 32'd0;
        end else if (!stall) begin
            r = model_redirect();
            if (m_pend && r[32]) begin
                miscompares++;
                $display("FAIL illegal_redirect_during_pending: redirect=%0d required 0", r[32]);
            end
            if (!imem_ready) begin
                m_instr = 32'd0; m_valid = 0;
                if (r[32] && !m_pend) begin m_pend = 1; m_pt = r[31:0]; end
            end else begin
                m_instr = mem_word(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1;
                m_pc = m_pend ? m_pt : r[32] ? r[31:0] : m_pc + 32'd4;
                m_pend = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (started) begin
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc_plus4", if_id_pc_plus4, m_pp4);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; id_valid = 0; id_jump = 2'b11; id_branch_inst = 0; id_rs_eq_rt = 0;
        id_rs_data = 0; id_instr_low = 0; id_pc_plus4 = 0;
    endtask

    task automatic set_id(input logic [1:0] j, input logic [1:0] br, input logic eq,
                          input logic [31:0] rs, input logic [25:0] low, input logic [31:0] pp4);
        id_valid = 1; id_jump = j; id_branch_inst = br; id_rs_eq_rt = eq;
        id_rs_data = rs; id_instr_low = low; id_pc_plus4 = pp4;
    endtask

    initial begin
        rst = 1; imem_ready = 1; idle();
        step(); started = 1; step();
        chk("reset_pc", pc, 32'h0);
        chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
        chk("reset_instr", if_id_instr, 32'h0);
        chk("reset_pp4", if_id_pc_plus4, 32'h0);
        rst = 0;
        step(); chk("seq_pc4", pc, 32'h4); chk("seq_instr0", if_id_instr, mem_word(32'h0));
        chk("seq_valid", {31'd0, if_id_valid}, 32'd1);
        step(); chk("seq_pc8", pc, 32'h8);
        step(); chk("seq_pcC", pc, 32'hC); chk("seq_instr8", if_id_instr, mem_word(32'h8));
        set_id(2'b01, 0, 0, 0, 26'h40, 32'h1000_0010);
        step(); chk("j_target", pc, 32'h1000_0100); chk("j_delay_slot", if_id_instr, mem_word(32'hC));
        set_id(2'b00, 2'b01, 1, 0, 26'h3FF_FFFE, 32'h20);
        step(); chk("beq_taken", pc, 32'h18);
        id_rs_eq_rt = 0;
        step(); chk("beq_not_taken", pc, 32'h1C);
        id_branch_inst = 2'b10;
        step(); chk("bne_taken", pc, 32'h18);
        id_rs_eq_rt = 1;
        step(); chk("bne_not_taken", pc, 32'h1C);
        set_id(2'b10, 0, 0, 32'h0000_0ABC, 0, 32'h20); imem_ready = 0;
        step(); chk("jr_wait_pc", pc, 32'h1C); chk("jr_bubble", {31'd0, if_id_valid}, 32'd0);
        idle();
        step(); chk("jr_wait_pc2", pc, 32'h1C);
        step(); chk("jr_wait_pc3", pc, 32'h1C); chk("jr_bubble_instr", if_id_instr, 32'h0);
        imem_ready = 1;
        step(); chk("jr_pending_target", pc, 32'h0ABC); chk("jr_delay_slot", if_id_instr, mem_word(32'h1C));
        set_id(2'b00, 2'b01, 1, 0, 26'h4, 32'h100); stall = 1;
        step(); chk("stall_pc", pc, 32'h0ABC); chk("stall_instr", if_id_instr, mem_word(32'h1C));
        step(); chk("stall_pc2", pc, 32'h0ABC); chk("stall_pp4", if_id_pc_plus4, 32'h20);
        stall = 0;
        step(); chk("stall_release_target", pc, 32'h110);
        idle();
        step(); chk("redirect_once", pc, 32'h114);
        set_id(2'b10, 0, 0, 32'hFFFF_FFFC, 0, 32'h0);
        step(); chk("wrap_setup", pc, 32'hFFFF_FFFC);
        idle();
        step(); chk("wrap_pc", pc, 32'h0); chk("wrap_pp4", if_id_pc_plus4, 32'h0);
        step(); chk("pre_pend_pc", pc, 32'h4);
        set_id(2'b10, 0, 0, 32'h0000_0ABC, 0, 32'h8); imem_ready = 0;
        step(); chk("pend_hold_pc", pc, 32'h4);
        idle(); rst = 1;
        #1; chk("rst_mid_pc", pc, 32'h0); chk("rst_mid_valid", {31'd0, if_id_valid}, 32'd0);
        step(); rst = 0; imem_ready = 1;
        step(); chk("pend_cleared", pc, 32'h4);
        for (int i = 0; i < 3000; i++) begin
            rst = (i % 500 == 250);
            stall = ($urandom_range(0, 7) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            id_jump = 2'($urandom); id_branch_inst = 2'($urandom); id_rs_eq_rt = 1'($urandom);
            id_rs_data = $urandom; id_instr_low = 26'($urandom); id_pc_plus4 = $urandom;
            id_valid = !m_pend && ($urandom_range(0, 2) != 0);
            step();
        end
        rst = 0; idle();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
